fetch_sequencer: RTL
====================

# fetch_sequencer

Sequencer for the MIPS instruction-fetch stage. It owns the program counter and drives the byte-wide, 128-entry instruction memory with one byte read per cycle. It assembles four consecutive bytes into a big-endian 32-bit instruction and presents it to decode over a valid/ready handshake. Branch/jump redirects from later stages restart the fetch at a new PC.

## Interface
- `ADDR_W`, 7, byte-address width of the instruction memory (128 bytes).
- `RESET_PC`, 7'd0, PC loaded on reset; must be word-aligned.
- `clk`  in  1  single clock, all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high; one clock; reset is synchronous and active-high.
- `mem_rd`  out  1  byte read strobe to the instruction memory.
- `mem_addr`  out  ADDR_W  byte address of the current read.
- `mem_rdata`  in  8  read byte; valid exactly one cycle after the cycle `mem_rd`/`mem_addr` were driven.
- `redirect_valid`  in  1  load a new PC and restart fetch.
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a complete instruction.
- `out_ready`  in  1  decode accepts the instruction when high together with `out_valid`.
- `out_instr`  out  32  assembled instruction, `{byte@PC, byte@PC+1, byte@PC+2, byte@PC+3}`.
- `out_pc`  out  ADDR_W  byte address of `out_instr`.

## Operation
- States: FETCH (issue bytes 0..3, 2-bit byte counter), DRAIN (capture last byte, no issue), HOLD (`out_valid`=1, wait for accept).
- FETCH: `mem_rd`=1, `mem_addr`=PC+cnt (mod 2^ADDR_W). Capture `mem_rdata` into the byte for cnt-1 when cnt>0. After cnt=3, go to DRAIN.
- DRAIN: `mem_rd`=0. Capture byte 3, latch `out_instr` and `out_pc`=PC, then go to HOLD.
- HOLD: while `out_ready`=0, `out_instr`/`out_pc` stay stable. On `out_valid && out_ready`: PC<=PC+4 (mod 128, so 124 wraps to 0), cnt<=0, go to FETCH.
- Redirect, evaluated in any state: PC<={redirect_pc[ADDR_W-1:2],2'b00}, cnt<=0, go to FETCH. Partially assembled bytes are discarded, and the `mem_rdata` returning in the next cycle is ignored.
- Priority: `rst` > `redirect_valid` > accept.
- Redirect in the same cycle as an accept: the instruction counts as consumed, and the PC comes from the redirect with no +4.
- Reset values: state FETCH, cnt 0, PC `RESET_PC`, `out_valid` 0, `out_instr` 0, `out_pc` `RESET_PC`, `mem_rd` 0, `mem_addr` `RESET_PC`.
- `mem_rd` and `mem_addr` are registered, so `mem_rd` is 0 during the reset cycle. The first read issues in the first cycle after `rst` deasserts.
- Memory contents are never written by this block.

## Timing
- Cycle t0 is the first FETCH cycle (after reset, a redirect, or an accept).
  - t0..t3: reads at PC..PC+3.
  - t1..t4: captures of bytes 0..3; t4 is DRAIN.
  - t5: `out_valid`=1.
- Fetch latency is 5 cycles.
- With `out_ready` held high, one instruction is accepted every 6 cycles.
- `out_valid` drops in the cycle after an accept or a redirect, and stays 0 until the new word completes.
- A redirect at t2 means the target is read at t3 and valid at t8. No byte of the old word leaks into `out_instr`.
- `rst` asserted mid-fetch: the next cycle shows reset values, and fetch resumes from `RESET_PC`.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {FETCH, DRAIN, HOLD};
  - `INSTR_W`=32 and `IMEM_ADDR_W`=7;
  - `PC_STEP`=4.
- One sub-module, `fetch_byte_packer`: a 4x8 capture register indexed by byte number, with a clear input. It produces the big-endian word.
- The FSM, PC and handshake stay in `fetch_sequencer`.

## Test plan
- Reset, memory bytes 0..7 = 8'h20,8'h08,8'h00,8'h05,8'h8C,8'h09,8'h00,8'h04, `out_ready`=1:
  - `mem_addr` sequence 0,1,2,3;
  - `out_instr`=32'h20080005 with `out_pc`=0 at t5;
  - then 32'h8C090004 with `out_pc`=4 six cycles later.
- Backpressure: hold `out_ready`=0 for 10 cycles in HOLD. `out_instr`/`out_pc` stay stable and `mem_rd`=0 throughout. Accept on release; the next fetch starts at PC+4.
- Redirect mid-fetch: `redirect_valid` with `redirect_pc`=7'd18 at t2. Reads restart at 16..19, `out_pc`=16, and `out_instr` contains only bytes 16..19.
- Wrap: redirect to 124, accept. `out_pc`=124, the next `out_pc`=0, and `mem_addr` goes 124..127 then 0..3.
- Simultaneous accept and redirect to 40: the next `out_pc`=40, not PC+4.
- `rst` pulsed at t3 of a fetch: `out_valid`=0, `mem_rd`=0 in the reset cycle. The first word after release is at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 7;
    localparam int PC_STEP     = 4;
endpackage

// File: rtl/fetch_byte_packer.sv
// Four-byte capture register producing a big-endian instruction word.
// The byte being written this cycle is forwarded so the word is complete on the final capture.
module fetch_byte_packer
    import fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               cap_en_i,
    input  logic [1:0]         cap_idx_i,
    input  logic [7:0]         cap_data_i,
    output logic [INSTR_W-1:0] word_o
);
    logic [7:0] bytes_q [4];
    logic [7:0] fwd     [4];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < 4; i++) bytes_q[i] <= '0;
        end else if (cap_en_i) begin
            bytes_q[cap_idx_i] <= cap_data_i;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fwd[i] = (cap_en_i && cap_idx_i == 2'(i)) ? cap_data_i : bytes_q[i];
        end
    end

    assign word_o = {fwd[0], fwd[1], fwd[2], fwd[3]};
endmodule

// File: rtl/fetch_sequencer.sv
// MIPS fetch sequencer: byte-serial reads, word assembly, valid/ready hand-off, redirects.
// Handshake: out_instr/out_pc are stable while out_valid=1; a transfer happens on a cycle with out_valid && out_ready.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output fetch_state_t       dbg_state
);
    fetch_state_t       state_q;
    logic [1:0]         cnt_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               out_valid_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic [ADDR_W-1:0]  out_pc_q;
    logic               mem_rd_q;
    logic [ADDR_W-1:0]  mem_addr_q;

    logic               accept;
    logic [ADDR_W-1:0]  redir_pc_d;
    logic [ADDR_W-1:0]  pc_inc_d;
    logic [ADDR_W-1:0]  fetch_addr_d;
    logic               cap_en;
    logic [1:0]         cap_idx;
    logic [INSTR_W-1:0] packed_word;

    assign accept       = out_valid_q && out_ready;
    assign redir_pc_d   = redirect_pc & ~ADDR_W'(3);
    assign pc_inc_d     = pc_q + ADDR_W'(PC_STEP);
    assign fetch_addr_d = pc_q + ADDR_W'(cnt_q) + ADDR_W'(1);

    // A byte read in cycle N lands in cycle N+1, so FETCH with cnt>0 stores byte cnt-1.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = cnt_q - 2'd1;
        if (state_q == FETCH) begin
            cap_en = (cnt_q != 2'd0);
        end else if (state_q == DRAIN) begin
            cap_en  = 1'b1;
            cap_idx = 2'd3;
        end
    end

    fetch_byte_packer u_packer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (redirect_valid || accept),
        .cap_en_i   (cap_en),
        .cap_idx_i  (cap_idx),
        .cap_data_i (mem_rdata),
        .word_o     (packed_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= RESET_PC;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
        end else if (redirect_valid) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            pc_q        <= redir_pc_d;
            out_valid_q <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= redir_pc_d;
        end else begin
            case (state_q)
                FETCH: begin
                    // Straight out of reset no read is in flight yet, so issue byte 0 first.
                    if (!mem_rd_q) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else if (cnt_q == 2'd3) begin
                        state_q  <= DRAIN;
                        mem_rd_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q + 2'd1;
                        mem_addr_q <= fetch_addr_d;
                    end
                end
                DRAIN: begin
                    out_instr_q <= packed_word;
                    out_pc_q    <= pc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        state_q     <= FETCH;
                        cnt_q       <= '0;
                        pc_q        <= pc_inc_d;
                        out_valid_q <= 1'b0;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= pc_inc_d;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign dbg_state = state_q;
endmodule
